// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of one register-bus slave among NUM_REQ requesters
module reg_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*14-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  axi_wreq,
  output logic [13:0]           axi_waddr,
  output logic [31:0]           axi_wdata,
  input  logic                  axi_wack,
  input  logic                  axi_werr,
  output logic                  axi_rreq,
  output logic [13:0]           axi_raddr,
  input  logic [31:0]           axi_rdata,
  input  logic                  axi_rack,
  input  logic                  axi_rerr
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr, gnt, gnt_nxt, idx;
  logic [NUM_REQ-1:0] gnt_oh, nxt_oh;
  logic [CW-1:0]      cnt;
  logic               lat_we, nxt_we, ack, err;
  logic [13:0]        nxt_addr;
  // Walk downward so the requester closest to rr_ptr is the last (winning) assignment
  always_comb begin
    gnt_nxt = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) gnt_nxt = idx;
    end
  end
  assign nxt_oh   = NUM_REQ'(1) << gnt_nxt;
  assign gnt_oh   = NUM_REQ'(1) << gnt;
  assign nxt_we   = req_we[gnt_nxt];
  assign nxt_addr = req_addr[gnt_nxt*14 +: 14];
  assign ack      = lat_we ? axi_wack : axi_rack;
  assign err      = lat_we ? axi_werr : axi_rerr;
  // Slave-side outputs are loaded on the IDLE edge so they are already registered in ISSUE
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      axi_wreq  <= 1'b0;
      axi_waddr <= '0;
      axi_wdata <= '0;
      axi_rreq  <= 1'b0;
      axi_raddr <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      axi_wreq  <= 1'b0;
      axi_rreq  <= 1'b0;
      if (state == IDLE && |req_valid) begin
        gnt       <= gnt_nxt;
        lat_we    <= nxt_we;
        req_ready <= nxt_oh;
        axi_wreq  <= nxt_we;
        axi_rreq  <= !nxt_we;
        if (nxt_we) begin
          axi_waddr <= nxt_addr;
          axi_wdata <= req_wdata[gnt_nxt*32 +: 32];
        end else
          axi_raddr <= nxt_addr;
        state <= ISSUE;
      end else if (state == ISSUE) begin
        rr_ptr <= IW'((int'(gnt) + 1) % NUM_REQ);
        cnt    <= '0;
        state  <= WAIT;
      end else if (state == WAIT) begin
        if (ack || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid <= gnt_oh;
          rsp_err   <= ack ? err : 1'b1;
          rsp_rdata <= (ack && !lat_we && !err) ? axi_rdata : 32'd0;
          state     <= RESP;
        end else
          cnt <= cnt + 1'b1;
      end else if (state == RESP)
        state <= IDLE;
    end
  end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: randomized scenario bench with a round-robin/response reference model
module tb_reg_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;
  logic            axi_clk = 0, axi_rst = 1;
  logic [N-1:0]    req_valid = '0, req_we = '0;
  logic [N*14-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [31:0]     rsp_rdata, axi_wdata, axi_rdata = '0;
  logic            rsp_err, axi_wreq, axi_rreq;
  logic [13:0]     axi_waddr, axi_raddr;
  logic            axi_wack = 0, axi_werr = 0, axi_rack = 0, axi_rerr = 0;
  int total = 0, bad = 0, rr = 0;

  reg_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_wreq(axi_wreq), .axi_waddr(axi_waddr), .axi_wdata(axi_wdata),
    .axi_wack(axi_wack), .axi_werr(axi_werr),
    .axi_rreq(axi_rreq), .axi_raddr(axi_raddr),
    .axi_rdata(axi_rdata), .axi_rack(axi_rack), .axi_rerr(axi_rerr)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic set_req(input int i, input bit we, input logic [13:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*14 +: 14] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) if (req_valid[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // One full transaction: bench acts as slave, acking d cycles after the ISSUE cycle
  task automatic transact(input bit drop, input bit stale, input int d, input bit noack,
                          input bit err_in, input logic [31:0] rd, input int exp_wait, input string nm);
    int g, w, n, exp_n;
    bit we, e, seen, extra;
    logic [13:0] a;
    logic [31:0] wd, exp_rd;
    logic [N-1:0] oh;
    g = exp_grant();
    we = req_we[g];
    a = req_addr[g*14 +: 14];
    wd = req_wdata[g*32 +: 32];
    oh = N'(1) << g;
    e = err_in & we;
    w = 0;
    do begin @(negedge axi_clk); w++; end while (req_ready === '0 && w < 10);
    total++;
    if (req_ready !== oh) begin bad++; $display("FAIL %s grant: req_ready=%b expected %b", nm, req_ready, oh); end
    if (exp_wait > 0) begin
      total++;
      if (w != exp_wait) begin bad++; $display("FAIL %s accept latency: got %0d cycles expected %0d", nm, w, exp_wait); end
    end
    total++;
    if ({axi_wreq, axi_rreq} !== {we, !we} || (we ? axi_waddr : axi_raddr) !== a || (we && axi_wdata !== wd)) begin
      bad++;
      $display("FAIL %s slave req: wreq=%b rreq=%b waddr=%h raddr=%h wdata=%h expected we=%b addr=%h wdata=%h",
               nm, axi_wreq, axi_rreq, axi_waddr, axi_raddr, axi_wdata, we, a, wd);
    end
    if (drop) req_valid[g] = 1'b0;
    rr = (g + 1) % N;
    if (stale) begin
      if (we) axi_wack = 1'b1; else axi_rack = 1'b1;
      axi_rdata = $urandom;
    end
    n = 0; seen = 0; extra = 0;
    while (!seen && n < 24) begin
      @(negedge axi_clk);
      n++;
      if (rsp_valid !== '0) seen = 1;
      else begin
        if (req_ready !== '0 || axi_wreq || axi_rreq) extra = 1;
        axi_wack  = we && !noack && n == d;
        axi_werr  = we && !noack && n == d && e;
        axi_rack  = !we && !noack && n == d;
        axi_rerr  = 1'b0;
        axi_rdata = (n == d) ? rd : $urandom;
      end
    end
    axi_wack = 0; axi_werr = 0; axi_rack = 0;
    exp_n  = noack ? TO + 1 : d + 1;
    exp_rd = (we || noack) ? 32'd0 : rd;
    total++;
    if (extra) begin bad++; $display("FAIL %s pulses: req_ready or slave request seen again before response", nm); end
    total++;
    if (rsp_valid !== oh || n != exp_n) begin
      bad++; $display("FAIL %s response: rsp_valid=%b after %0d cycles expected %b after %0d", nm, rsp_valid, n, oh, exp_n);
    end
    total++;
    if (rsp_err !== (noack | e) || rsp_rdata !== exp_rd) begin
      bad++; $display("FAIL %s data: rsp_err=%b rsp_rdata=%h expected %b %h", nm, rsp_err, rsp_rdata, noack | e, exp_rd);
    end
  endtask

  task automatic test_reset();
    axi_rst = 1;
    repeat (3) @(negedge axi_clk);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, axi_wreq, axi_waddr, axi_wdata, axi_rreq, axi_raddr} !== '0) begin
      bad++; $display("FAIL reset outputs: req_ready=%b rsp_valid=%b rsp_rdata=%h wreq=%b rreq=%b expected all 0",
                      req_ready, rsp_valid, rsp_rdata, axi_wreq, axi_rreq);
    end
    axi_rst = 0;
    rr = 0;
  endtask

  task automatic test_write();
    set_req(0, 1, 14'h0801, 32'hDEADBEEF);
    transact(1, 0, 1, 0, 0, 32'h0, 1, "write");
  endtask

  task automatic test_read();
    set_req(1, 0, 14'h0801, 32'h0);
    transact(1, 0, 1, 0, 0, 32'hDEADBEEF, 0, "read");
  endtask

  task automatic test_round_robin();
    set_req(0, 1, 14'h0100, 32'h11112222);
    set_req(1, 0, 14'h0200, 32'h0);
    for (int i = 0; i < 4; i++) transact(0, 0, 1, 0, 0, $urandom, 2, "rr");
    req_valid = '0;
  endtask

  task automatic test_timeout();
    set_req(0, 0, 14'h3F00, 32'h0);
    transact(1, 0, 1, 1, 0, 32'h0, 0, "timeout");
  endtask

  task automatic test_werr();
    bit seen;
    set_req(1, 1, 14'h0010, 32'h5A5A5A5A);
    transact(1, 0, 2, 0, 1, 32'h0, 0, "werr");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge axi_clk);
      if (rsp_valid !== '0) seen = 1;
      axi_wack = (i == 0);
      axi_werr = (i == 0);
    end
    total++;
    if (seen) begin bad++; $display("FAIL spurious ack: rsp_valid seen while idle, expected none"); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1)) set_req(i, 1'($urandom), 14'($urandom), $urandom);
      if (req_valid == '0) set_req($urandom_range(0, N - 1), 1'($urandom), 14'($urandom), $urandom);
      transact(1, 1'($urandom), $urandom_range(1, 5), $urandom_range(0, 7) == 0, 1'($urandom), $urandom, 0, "random");
    end
    req_valid = '0;
  endtask

  task automatic test_reset_abort();
    int w;
    bit seen;
    set_req(0, 0, 14'h1234, 32'h0);
    w = 0;
    do begin @(negedge axi_clk); w++; end while (req_ready === '0 && w < 10);
    req_valid = '0;
    @(negedge axi_clk);
    axi_rst = 1;
    @(negedge axi_clk);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, axi_wreq, axi_waddr, axi_wdata, axi_rreq, axi_raddr} !== '0) begin
      bad++; $display("FAIL abort outputs: rsp_rdata=%h rsp_err=%b raddr=%h waddr=%h expected all 0",
                      rsp_rdata, rsp_err, axi_raddr, axi_waddr);
    end
    axi_rst = 0;
    rr = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge axi_clk);
      if (rsp_valid !== '0) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort response: rsp_valid seen for aborted transaction"); end
    set_req(0, 1, 14'h0042, 32'hCAFEF00D);
    set_req(1, 0, 14'h0043, 32'h0);
    transact(1, 0, 1, 0, 0, 32'h0, 0, "post reset 0");
    transact(1, 0, 3, 0, 0, 32'h13572468, 0, "post reset 1");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_werr();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
